line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W  8    pixel width in bits
  IMG_W   640  active pixels per line
  IMG_H   480  active lines per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk          in   1       clock, all state on rising edge
  reset        in   1       asynchronous, active-high reset
  pix_in       in   DATA_W  incoming pixel, raster order
  pix_valid    in   1       pix_in valid this cycle
  frame_start  in   1       qualifies pix_in as pixel (0,0); ignored when pix_valid=0
  tap_top      out  DATA_W  pixel from line row-2, same column
  tap_mid      out  DATA_W  pixel from line row-1, same column
  tap_bot      out  DATA_W  current pixel (row)
  shift_en     out  1       enable strobe for downstream 3-column window registers
  win_valid    out  1       full 3x3 window available at downstream registers
  col_out      out  clog2(IMG_W)  column of the pixel presented on taps
  row_out      out  clog2(IMG_H)  row of the pixel presented on taps
REQ-003 clk is the clock; reset is asynchronous, active-high.

Function
REQ-004 Block SHALL hold two line memories (line0 = row-2, line1 = row-1), IMG_W x DATA_W each, addressed by the internal column counter col.
REQ-005 On a cycle with pix_valid=1, block SHALL read line0[col] and line1[col], write line1[col] <= pix_in and line0[col] <= old line1[col] (read-before-write).
REQ-006 Taps SHALL be registered: tap_top=old line0[col], tap_mid=old line1[col], tap_bot=pix_in, valid one cycle after acceptance (latency 1).
REQ-007 shift_en SHALL equal pix_valid delayed one cycle; taps, col_out, row_out SHALL update only when shift_en rises for that pixel and hold otherwise.
REQ-008 col SHALL increment on each accepted pixel, wrapping IMG_W-1 -> 0; row SHALL increment on that wrap, wrapping IMG_H-1 -> 0.
REQ-009 Accepted pixel with frame_start=1 SHALL be treated as col=0,row=0 regardless of counter state; next pixel is col=1,row=0.
REQ-010 win_valid SHALL be asserted together with shift_en iff the presented pixel has row>=2 and col>=2; otherwise 0.
REQ-011 pix_valid=0 cycles (gaps) SHALL not change counters or memories; shift_en=0 and win_valid=0 in the following cycle.
REQ-012 Line memories SHALL not be cleared by reset or frame_start; tap contents for rows 0-1 are undefined-but-stable data, qualified only by win_valid.
REQ-013 Back-to-back pixels SHALL be accepted every cycle with no stall; block has no backpressure.

Reset
REQ-014 While reset=1: col=0, row=0, tap_top/tap_mid/tap_bot=0, col_out=0, row_out=0, shift_en=0, win_valid=0.
REQ-015 Reset asserted mid-line SHALL abandon the partial frame; first accepted pixel after release is treated as (0,0) even without frame_start.
REQ-016 No output SHALL change on the first rising clk edge after release unless pix_valid=1 on that edge.

Verification (bench uses IMG_W=4, IMG_H=4, DATA_W=8)
REQ-017 Stream pixels 0x00..0x0F continuously with frame_start on first -> shift_en high 16 cycles starting 1 cycle later; at pixel 0x0A: tap_top=0x02, tap_mid=0x06, tap_bot=0x0A, win_valid=1.
REQ-018 Same stream -> win_valid high exactly for pixels 0x0A,0x0B,0x0E,0x0F (4 strobes); low for all others.
REQ-019 Insert 3 idle cycles between each pixel -> identical tap values/win_valid sequence as REQ-017/018, shift_en pulses 1 cycle each.
REQ-020 After 6 pixels, assert frame_start with next pixel 0x55 -> col_out=0,row_out=0 presented with tap_bot=0x55, win_valid=0.
REQ-021 Assert reset for 2 cycles after pixel 0x07 -> all outputs 0 during reset; next pixel presented with col_out=0,row_out=0.
REQ-022 Stream 2 full frames -> row wraps 3->0, second frame pixel (2,2) presents tap_top equal to that frame's pixel (0,2), win_valid=1.

Source files
------------

// File: rtl/line_window_buffer.sv
// Line buffer feeding a 3x3 sliding window: two line memories give the pixels
// directly above the current one, plus raster position and window qualifiers.
module line_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         pix_in,
    input  logic                      pix_valid,
    input  logic                      frame_start,
    output logic [DATA_W-1:0]         tap_top,
    output logic [DATA_W-1:0]         tap_mid,
    output logic [DATA_W-1:0]         tap_bot,
    output logic                      shift_en,
    output logic                      win_valid,
    output logic [$clog2(IMG_W)-1:0]  col_out,
    output logic [$clog2(IMG_H)-1:0]  row_out
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // line0_mem holds row-2, line1_mem holds row-1; never cleared
    logic [DATA_W-1:0] line0_mem [IMG_W];
    logic [DATA_W-1:0] line1_mem [IMG_W];

    logic [COL_W-1:0]  col_q, col_d, col_sel;
    logic [ROW_W-1:0]  row_q, row_d, row_sel;
    logic [DATA_W-1:0] tap_top_q, tap_top_d;
    logic [DATA_W-1:0] tap_mid_q, tap_mid_d;
    logic [DATA_W-1:0] tap_bot_q, tap_bot_d;
    logic [COL_W-1:0]  col_out_q, col_out_d;
    logic [ROW_W-1:0]  row_out_q, row_out_d;
    logic              shift_en_q, shift_en_d;
    logic              win_valid_q, win_valid_d;

    // Position of the accepted pixel, counters and next output values
    always_comb begin
        col_sel     = col_q;
        row_sel     = row_q;
        col_d       = col_q;
        row_d       = row_q;
        tap_top_d   = tap_top_q;
        tap_mid_d   = tap_mid_q;
        tap_bot_d   = tap_bot_q;
        col_out_d   = col_out_q;
        row_out_d   = row_out_q;
        shift_en_d  = pix_valid;
        win_valid_d = 1'b0;
        // frame_start overrides whatever position the counters have drifted to
        if (pix_valid && frame_start) begin
            col_sel = '0;
            row_sel = '0;
        end else begin
            col_sel = col_q;
            row_sel = row_q;
        end
        if (pix_valid) begin
            tap_top_d   = line0_mem[col_sel];
            tap_mid_d   = line1_mem[col_sel];
            tap_bot_d   = pix_in;
            col_out_d   = col_sel;
            row_out_d   = row_sel;
            win_valid_d = (row_sel >= ROW_W'(2)) && (col_sel >= COL_W'(2));
            if (col_sel == COL_LAST) begin
                col_d = '0;
                if (row_sel == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_sel + ROW_W'(1);
                end
            end else begin
                col_d = col_sel + COL_W'(1);
                row_d = row_sel;
            end
        end else begin
            win_valid_d = 1'b0;
        end
    end

    // Line memories: read-before-write shift of the column down one line
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            line1_mem[col_sel] <= pix_in;
            line0_mem[col_sel] <= line1_mem[col_sel];
        end
    end

    // Counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            tap_top_q   <= '0;
            tap_mid_q   <= '0;
            tap_bot_q   <= '0;
            col_out_q   <= '0;
            row_out_q   <= '0;
            shift_en_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            tap_top_q   <= tap_top_d;
            tap_mid_q   <= tap_mid_d;
            tap_bot_q   <= tap_bot_d;
            col_out_q   <= col_out_d;
            row_out_q   <= row_out_d;
            shift_en_q  <= shift_en_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign tap_top   = tap_top_q;
    assign tap_mid   = tap_mid_q;
    assign tap_bot   = tap_bot_q;
    assign col_out   = col_out_q;
    assign row_out   = row_out_q;
    assign shift_en  = shift_en_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a 4x4 image: a per-column history
// model predicts every output each cycle, plus hand-computed literal checks.
module tb_line_window_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pix_in = 8'h00;
    logic       pix_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] tap_top, tap_mid, tap_bot;
    logic       shift_en, win_valid;
    logic [1:0] col_out, row_out;

    line_window_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .frame_start(frame_start), .tap_top(tap_top), .tap_mid(tap_mid),
        .tap_bot(tap_bot), .shift_en(shift_en), .win_valid(win_valid),
        .col_out(col_out), .row_out(row_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: every value ever written to each column, in order
    logic [7:0] hist [W][64];
    int         hn [W];
    int         m_col, m_row;
    logic [7:0] exp_top, exp_mid, exp_bot;
    int         exp_col, exp_row;
    bit         exp_shift, exp_win, top_known, mid_known;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0;
        exp_top = 8'h00; exp_mid = 8'h00; exp_bot = 8'h00;
        exp_col = 0; exp_row = 0; exp_shift = 1'b0; exp_win = 1'b0;
        top_known = 1'b1; mid_known = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] p, input logic v, input logic fs);
        int c;
        if (!v) begin
            exp_shift = 1'b0;
            exp_win   = 1'b0;
        end else begin
            if (fs) begin
                m_col = 0; m_row = 0;
            end
            c = m_col;
            exp_bot = p; exp_col = c; exp_row = m_row; exp_shift = 1'b1;
            exp_win = (m_row >= 2) && (c >= 2);
            mid_known = (hn[c] >= 1);
            top_known = (hn[c] >= 2);
            if (mid_known) exp_mid = hist[c][hn[c]-1];
            if (top_known) exp_top = hist[c][hn[c]-2];
            hist[c][hn[c]] = p;
            hn[c]++;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % H;
            end
        end
    endtask

    task automatic apply(input logic [7:0] p, input logic v, input logic fs);
        pix_in = p; pix_valid = v; frame_start = fs;
        @(posedge clk);
        model_step(p, v, fs);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // Compare process: every cycle, DUT against model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("shift_en", 32'(shift_en), 32'(exp_shift));
                chk("win_valid", 32'(win_valid), 32'(exp_win));
                chk("col_out", 32'(col_out), 32'(exp_col));
                chk("row_out", 32'(row_out), 32'(exp_row));
                chk("tap_bot", 32'(tap_bot), 32'(exp_bot));
                if (mid_known) chk("tap_mid", 32'(tap_mid), 32'(exp_mid));
                if (top_known) chk("tap_top", 32'(tap_top), 32'(exp_top));
            end
        end
    end

    initial begin
        logic [15:0] win_mask;
        int          shift_cnt;
        for (int i = 0; i < W; i++) hn[i] = 0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;
        do_reset(2);
        apply(8'h00, 1'b0, 1'b0);
        chk("post_reset_hold", {20'h0, tap_top, tap_bot, shift_en, win_valid, col_out}, 32'h0);

        // Continuous frame 0x00..0x0F
        win_mask = 16'h0000; shift_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            apply(8'(i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
            if (win_valid) win_mask[i] = 1'b1;
            if (shift_en) shift_cnt++;
            if (i == 10) begin
                chk("px0A_top", 32'(tap_top), 32'h02);
                chk("px0A_mid", 32'(tap_mid), 32'h06);
                chk("px0A_bot", 32'(tap_bot), 32'h0A);
                chk("px0A_win", 32'(win_valid), 32'h1);
            end
        end
        chk("cont_win_mask", 32'(win_mask), 32'h0000CC00);
        chk("cont_shift_cnt", 32'(shift_cnt), 32'd16);
        apply(8'h00, 1'b0, 1'b0);

        // Same frame with 3 idle cycles after every pixel
        win_mask = 16'h0000; shift_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            apply(8'(i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
            if (win_valid) win_mask[i] = 1'b1;
            if (i == 10) begin
                chk("gap_px0A_top", 32'(tap_top), 32'h02);
                chk("gap_px0A_mid", 32'(tap_mid), 32'h06);
            end
            for (int g = 0; g < 3; g++) begin
                apply(8'hEE, 1'b0, 1'b0);
                if (shift_en) shift_cnt++;
            end
        end
        chk("gap_win_mask", 32'(win_mask), 32'h0000CC00);
        chk("gap_idle_shift", 32'(shift_cnt), 32'd0);

        // frame_start after 6 pixels restarts at (0,0)
        for (int i = 0; i < 6; i++) apply(8'(8'h20 + i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
        apply(8'h55, 1'b1, 1'b1);
        chk("fs_restart_pos", {28'h0, row_out, col_out}, 32'h0);
        chk("fs_restart_bot", 32'(tap_bot), 32'h55);
        chk("fs_restart_win", 32'(win_valid), 32'h0);
        apply(8'h56, 1'b1, 1'b0);
        chk("fs_next_col", 32'(col_out), 32'h1);

        // Reset mid-frame after pixel 0x07
        for (int i = 0; i < 8; i++) apply(8'(i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_async_clear", {tap_top, tap_mid, tap_bot, 2'b00, row_out, col_out, shift_en, win_valid}, 32'h0);
        #1;
        do_reset(2);
        apply(8'h99, 1'b1, 1'b0);
        chk("after_reset_pos", {28'h0, row_out, col_out}, 32'h0);
        chk("after_reset_bot", 32'(tap_bot), 32'h99);

        // Two full frames, frame_start only on the first
        for (int i = 0; i < 32; i++) begin
            apply((i < 16) ? 8'(8'h40 + i) : 8'(8'h70 + i), 1'b1, (i == 0) ? 1'b1 : 1'b0);
            if (i == 16) chk("wrap_pos", {28'h0, row_out, col_out}, 32'h0);
            if (i == 26) begin
                chk("f2_22_top", 32'(tap_top), 32'h82);
                chk("f2_22_win", 32'(win_valid), 32'h1);
                chk("f2_22_pos", {28'h0, row_out, col_out}, 32'hA);
            end
        end
        apply(8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
